pwm_capture: RTL

Wishbone-slave input-capture peripheral that measures an external PWM waveform. It reports the high time and period in prescaled ticks, making it the receiving end of the timer's compare/PWM outputs. It is memory-mapped next to the timer and raises a level interrupt when a measurement completes, overruns or times out.

---
 rtl/pwm_capture_if.sv | 22 ++
 rtl/pwm_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// Wishbone register-access bus (interface wb_bus) used by the pwm_capture peripheral.
interface wb_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;

  modport master (
    output addr, wdata, sel, we, stb, cyc,
    input  rdata, ack, err
  );

  modport slave (
    input  addr, wdata, sel, we, stb, cyc,
    output rdata, ack, err
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM input-capture peripheral: measures high time and period in prescaled ticks.
// Optional 3-sample input stability filter enabled by defining CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter logic [31:0] BaseAddr = 32'h4040
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic capture_in,
  output logic capture_irq_out,
  wb_bus.slave bus_slave
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StArm  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StLow  = 2'd3;

  logic [2:0]  ctrl_q, ctrl_d;
  logic        valid_q, valid_d, ovr_q, ovr_d, to_q, to_d;
  logic [31:0] presc_q, presc_d, tmo_q, tmo_d;
  logic [31:0] high_q, high_d, period_q, period_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] pcnt_q, pcnt_d, cnt_q, cnt_d;
  logic [31:0] pcnt_next, cnt_next;
  logic [1:0]  sync_q;
  logic        lvl_q, lvl_prev_q;
  logic        irq_q;
  logic        rise, fall, tick, tmo_hit, done, to_set, abort;

  // Bus decode
  logic        acc, wr, rd;
  logic        hit_ctrl, hit_stat, hit_presc, hit_tmo, hit_high, hit_period;
  logic [31:0] mask, rdata;
  logic [2:0]  clr;

  assign acc        = bus_slave.cyc & bus_slave.stb;
  assign wr         = acc & bus_slave.we;
  assign rd         = acc & ~bus_slave.we;
  assign hit_ctrl   = (bus_slave.addr == BaseAddr);
  assign hit_stat   = (bus_slave.addr == BaseAddr + 32'h4);
  assign hit_presc  = (bus_slave.addr == BaseAddr + 32'h8);
  assign hit_tmo    = (bus_slave.addr == BaseAddr + 32'hC);
  assign hit_high   = (bus_slave.addr == BaseAddr + 32'h10);
  assign hit_period = (bus_slave.addr == BaseAddr + 32'h14);
  assign mask       = {{8{bus_slave.sel[3]}}, {8{bus_slave.sel[2]}},
                       {8{bus_slave.sel[1]}}, {8{bus_slave.sel[0]}}};

  assign bus_slave.ack   = acc;
  assign bus_slave.err   = 1'b0;
  assign bus_slave.rdata = rdata;

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (hit_ctrl)        rdata = {29'h0, ctrl_q};
      else if (hit_stat)   rdata = {29'h0, to_q, ovr_q, valid_q};
      else if (hit_presc)  rdata = presc_q;
      else if (hit_tmo)    rdata = tmo_q;
      else if (hit_high)   rdata = high_q;
      else if (hit_period) rdata = period_q;
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    tmo_d   = tmo_q;
    clr     = 3'b000;
    if (wr && hit_ctrl)  ctrl_d  = (ctrl_q & ~mask[2:0]) | (bus_slave.wdata[2:0] & mask[2:0]);
    if (wr && hit_presc) presc_d = (presc_q & ~mask) | (bus_slave.wdata & mask);
    if (wr && hit_tmo)   tmo_d   = (tmo_q & ~mask) | (bus_slave.wdata & mask);
    if (wr && hit_stat)  clr     = bus_slave.wdata[2:0] & mask[2:0];
  end

  assign abort = wr & (hit_presc | hit_tmo);

  // Input path: synchronizer, optional stability filter, polarity, edge detect
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      sync_q     <= 2'b00;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], capture_in};
      lvl_prev_q <= lvl_q;
    end
  end

`ifdef CAPTURE_FILTER_EN
  logic [1:0] hist_q;
  logic       stable;

  assign stable = (sync_q[1] == hist_q[0]) && (sync_q[1] == hist_q[1]);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      hist_q <= 2'b00;
      lvl_q  <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      if (stable) lvl_q <= sync_q[1] ^ ctrl_q[2];
    end
  end
`else
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) lvl_q <= 1'b0;
    else           lvl_q <= sync_q[1] ^ ctrl_q[2];
  end
`endif

  assign rise = lvl_q & ~lvl_prev_q;
  assign fall = ~lvl_q & lvl_prev_q;

  // Timebase: saturating tick counter behind a 0..PRESCALE prescaler
  assign tick      = (pcnt_q == presc_q);
  assign pcnt_next = tick ? 32'h0 : pcnt_q + 32'h1;
  assign cnt_next  = (tick && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'h1 : cnt_q;
  assign tmo_hit   = (tmo_q != 32'h0) && (cnt_q == tmo_q);

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    period_d = period_q;
    done     = 1'b0;
    to_set   = 1'b0;
    if (!ctrl_d[0]) begin
      state_d = StIdle;
      pcnt_d  = 32'h0;
      cnt_d   = 32'h0;
    end else if (abort) begin
      state_d = StArm;
      pcnt_d  = 32'h0;
      cnt_d   = 32'h0;
    end else begin
      case (state_q)
        StIdle: state_d = StArm;
        StArm: if (rise) state_d = StHigh;
        StHigh, StLow: begin
          if (tmo_hit) begin
            // Timeout beats any edge in the same cycle
            to_set  = 1'b1;
            state_d = StArm;
            pcnt_d  = 32'h0;
            cnt_d   = 32'h0;
          end else if (state_q == StHigh && fall) begin
            high_d  = cnt_next;
            state_d = StLow;
            pcnt_d  = pcnt_next;
            cnt_d   = cnt_next;
          end else if (state_q == StLow && rise) begin
            period_d = cnt_next;
            done     = 1'b1;
            state_d  = StHigh;
            pcnt_d   = 32'h0;
            cnt_d    = 32'h0;
          end else begin
            pcnt_d = pcnt_next;
            cnt_d  = cnt_next;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Hardware set wins over a same-cycle W1C
  assign valid_d = (valid_q & ~clr[0]) | done;
  assign ovr_d   = (ovr_q & ~clr[1]) | (done & valid_q);
  assign to_d    = (to_q & ~clr[2]) | to_set;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ctrl_q   <= 3'b000;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      to_q     <= 1'b0;
      presc_q  <= 32'h0;
      tmo_q    <= 32'h0;
      high_q   <= 32'h0;
      period_q <= 32'h0;
      state_q  <= StIdle;
      pcnt_q   <= 32'h0;
      cnt_q    <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      to_q     <= to_d;
      presc_q  <= presc_d;
      tmo_q    <= tmo_d;
      high_q   <= high_d;
      period_q <= period_d;
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
      irq_q    <= ctrl_q[1] & (valid_q | ovr_q | to_q);
    end
  end

  assign capture_irq_out = irq_q;

endmodule
